// File: rtl/video_timing_pattern_gen.sv
// Programmable raster timing generator with built-in test patterns.
// Timing, polarity and pattern are shadowed and only change at frame boundaries.
module video_timing_pattern_gen #(
    parameter int B        = 8,
    parameter int X_BITS   = 12,
    parameter int Y_BITS   = 12,
    parameter int F_BITS   = 12,
    parameter int CHK_LOG2 = 5
) (
    input  logic                clk_i,
    input  logic                resetb_i,
    input  logic                enable_i,
    input  logic [X_BITS-1:0]   h_active_i,
    input  logic [X_BITS-1:0]   h_fp_i,
    input  logic [X_BITS-1:0]   h_sync_i,
    input  logic [X_BITS-1:0]   h_bp_i,
    input  logic [Y_BITS-1:0]   v_active_i,
    input  logic [Y_BITS-1:0]   v_fp_i,
    input  logic [Y_BITS-1:0]   v_sync_i,
    input  logic [Y_BITS-1:0]   v_bp_i,
    input  logic                hs_pol_i,
    input  logic                vs_pol_i,
    input  logic [2:0]          pattern_i,
    input  logic [B-1:0]        solid_r_i,
    input  logic [B-1:0]        solid_g_i,
    input  logic [B-1:0]        solid_b_i,
    input  logic [B+F_BITS-1:0] ramp_step_i,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic                fv_o,
    output logic [B-1:0]        red_o,
    output logic [B-1:0]        green_o,
    output logic [B-1:0]        blue_o,
    output logic [X_BITS-1:0]   x_o,
    output logic [Y_BITS-1:0]   y_o,
    output logic                frame_start_o,
    output logic                frame_end_o,
    output logic                line_start_o,
    output logic                cfg_err_o,
    output logic [15:0]         frame_cnt_o
);

    localparam int A_BITS = B + F_BITS;

    logic [X_BITS-1:0] h_act_r, h_fp_r, h_sync_r, h_bp_r;
    logic [Y_BITS-1:0] v_act_r, v_fp_r, v_sync_r, v_bp_r;
    logic              hs_pol_r, vs_pol_r;
    logic [2:0]        pat_r;
    logic              en_d_r;
    logic [X_BITS-1:0] h_cnt_r, bar_cnt_r;
    logic [Y_BITS-1:0] v_cnt_r;
    logic [A_BITS-1:0] acc_r;
    logic [2:0]        bar_idx_r;

    logic [X_BITS-1:0] h_total_s, bar_w_s;
    logic [Y_BITS-1:0] v_total_s;
    logic              run_s, h_last_s, v_last_s, cfg_ok_s, load_s, load_ok_s;
    logic              hs_pol_nxt_s, vs_pol_nxt_s;
    logic              h_act_px_s, v_act_ln_s, de_s, hs_act_s, vs_act_s;
    logic              border_s, chk_s, mbar_s, fe_s;
    logic [3*B-1:0]    pix_s;

    function automatic logic [3*B-1:0] expand(input logic [2:0] c);
        return {{B{c[2]}}, {B{c[1]}}, {B{c[0]}}};
    endfunction

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    assign h_total_s  = h_act_r + h_fp_r + h_sync_r + h_bp_r;
    assign v_total_s  = v_act_r + v_fp_r + v_sync_r + v_bp_r;
    // The enable-rise cycle only loads the shadow; counting starts on the next cycle.
    assign run_s      = enable_i & en_d_r;
    assign h_last_s   = (h_cnt_r == h_total_s - X_BITS'(1));
    assign v_last_s   = (v_cnt_r == v_total_s - Y_BITS'(1));
    assign cfg_ok_s   = (h_active_i != X_BITS'(0)) && (h_fp_i != X_BITS'(0)) &&
                        (h_sync_i != X_BITS'(0)) && (h_bp_i != X_BITS'(0)) &&
                        (v_active_i != Y_BITS'(0)) && (v_fp_i != Y_BITS'(0)) &&
                        (v_sync_i != Y_BITS'(0)) && (v_bp_i != Y_BITS'(0));
    assign load_s     = (enable_i & ~en_d_r) | (run_s & h_last_s & v_last_s);
    assign load_ok_s  = load_s & cfg_ok_s;
    assign hs_pol_nxt_s = load_ok_s ? hs_pol_i : hs_pol_r;
    assign vs_pol_nxt_s = load_ok_s ? vs_pol_i : vs_pol_r;

    assign h_act_px_s = (h_cnt_r < h_act_r);
    assign v_act_ln_s = (v_cnt_r < v_act_r);
    assign de_s       = h_act_px_s & v_act_ln_s;
    assign hs_act_s   = (h_cnt_r >= h_act_r + h_fp_r) && (h_cnt_r < h_act_r + h_fp_r + h_sync_r);
    assign vs_act_s   = (v_cnt_r >= v_act_r + v_fp_r) && (v_cnt_r < v_act_r + v_fp_r + v_sync_r);
    assign fe_s       = (h_cnt_r == h_act_r) && (v_cnt_r == v_act_r - Y_BITS'(1));
    assign bar_w_s    = h_act_r >> 3;
    assign border_s   = (h_cnt_r == X_BITS'(0)) || (h_cnt_r == h_act_r - X_BITS'(1)) ||
                        (v_cnt_r == Y_BITS'(0)) || (v_cnt_r == v_act_r - Y_BITS'(1));
    assign chk_s      = h_cnt_r[CHK_LOG2] ^ v_cnt_r[CHK_LOG2];
    assign mbar_s     = ((h_cnt_r >> CHK_LOG2) == X_BITS'(frame_cnt_o[X_BITS-CHK_LOG2-1:0]));

    // Shadow configuration and enable-edge tracking.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            h_act_r  <= X_BITS'(640);
            h_fp_r   <= X_BITS'(16);
            h_sync_r <= X_BITS'(96);
            h_bp_r   <= X_BITS'(48);
            v_act_r  <= Y_BITS'(480);
            v_fp_r   <= Y_BITS'(10);
            v_sync_r <= Y_BITS'(2);
            v_bp_r   <= Y_BITS'(33);
            hs_pol_r <= 1'b0;
            vs_pol_r <= 1'b0;
            pat_r    <= 3'd0;
            en_d_r   <= 1'b0;
        end else begin
            en_d_r <= enable_i;
            if (load_ok_s) begin
                h_act_r  <= h_active_i;
                h_fp_r   <= h_fp_i;
                h_sync_r <= h_sync_i;
                h_bp_r   <= h_bp_i;
                v_act_r  <= v_active_i;
                v_fp_r   <= v_fp_i;
                v_sync_r <= v_sync_i;
                v_bp_r   <= v_bp_i;
                hs_pol_r <= hs_pol_i;
                vs_pol_r <= vs_pol_i;
                pat_r    <= pattern_i;
            end
        end
    end

    // Raster counters plus per-line ramp accumulator and colour-bar stepper.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            h_cnt_r   <= X_BITS'(0);
            v_cnt_r   <= Y_BITS'(0);
            acc_r     <= A_BITS'(0);
            bar_cnt_r <= X_BITS'(0);
            bar_idx_r <= 3'd0;
        end else if (!run_s) begin
            h_cnt_r   <= X_BITS'(0);
            v_cnt_r   <= Y_BITS'(0);
            acc_r     <= A_BITS'(0);
            bar_cnt_r <= X_BITS'(0);
            bar_idx_r <= 3'd0;
        end else if (h_last_s) begin
            h_cnt_r   <= X_BITS'(0);
            v_cnt_r   <= v_last_s ? Y_BITS'(0) : v_cnt_r + Y_BITS'(1);
            acc_r     <= A_BITS'(0);
            bar_cnt_r <= X_BITS'(0);
            bar_idx_r <= 3'd0;
        end else begin
            h_cnt_r <= h_cnt_r + X_BITS'(1);
            if (h_act_px_s) begin
                acc_r <= acc_r + ramp_step_i;
                if (bar_cnt_r == bar_w_s - X_BITS'(1)) begin
                    bar_cnt_r <= X_BITS'(0);
                    bar_idx_r <= (bar_idx_r == 3'd7) ? 3'd7 : bar_idx_r + 3'd1;
                end else begin
                    bar_cnt_r <= bar_cnt_r + X_BITS'(1);
                end
            end
        end
    end

    // Pattern colour for the current counter position.
    always_comb begin
        pix_s = {(3*B){1'b0}};
        case (pat_r)
            3'd0:    pix_s = {solid_r_i, solid_g_i, solid_b_i};
            3'd1:    pix_s = expand({3{border_s}});
            3'd2:    pix_s = {3{acc_r[A_BITS-1:F_BITS]}};
            3'd3:    pix_s = expand((bar_w_s == X_BITS'(0)) ? 3'b111 : bar_rgb(bar_idx_r));
            3'd4:    pix_s = expand({3{chk_s}});
            3'd5:    pix_s = expand({3{mbar_s}});
            default: pix_s = {(3*B){1'b0}};
        endcase
    end

    // Registered, mutually aligned outputs.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            de_o          <= 1'b0;
            fv_o          <= 1'b0;
            {red_o, green_o, blue_o} <= {(3*B){1'b0}};
            x_o           <= X_BITS'(0);
            y_o           <= Y_BITS'(0);
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            line_start_o  <= 1'b0;
            cfg_err_o     <= 1'b0;
            frame_cnt_o   <= 16'd0;
        end else begin
            cfg_err_o <= load_s & ~cfg_ok_s;
            if (!run_s) begin
                hsync_o       <= ~hs_pol_nxt_s;
                vsync_o       <= ~vs_pol_nxt_s;
                de_o          <= 1'b0;
                fv_o          <= 1'b0;
                {red_o, green_o, blue_o} <= {(3*B){1'b0}};
                x_o           <= X_BITS'(0);
                y_o           <= Y_BITS'(0);
                frame_start_o <= 1'b0;
                frame_end_o   <= 1'b0;
                line_start_o  <= 1'b0;
            end else begin
                hsync_o       <= hs_act_s ^ ~hs_pol_r;
                vsync_o       <= vs_act_s ^ ~vs_pol_r;
                de_o          <= de_s;
                fv_o          <= v_act_ln_s;
                {red_o, green_o, blue_o} <= de_s ? pix_s : {(3*B){1'b0}};
                x_o           <= de_s ? h_cnt_r : X_BITS'(0);
                y_o           <= de_s ? v_cnt_r : Y_BITS'(0);
                frame_start_o <= (h_cnt_r == X_BITS'(0)) && (v_cnt_r == Y_BITS'(0));
                frame_end_o   <= fe_s;
                line_start_o  <= (h_cnt_r == X_BITS'(0)) && v_act_ln_s;
                if (fe_s) begin
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench for video_timing_pattern_gen: a behavioural raster model
// predicts every output cycle by cycle across timing and pattern changes.
module tb_video_timing_pattern_gen;

    logic        clk_i = 1'b0;
    logic        resetb_i;
    logic        enable_i;
    logic [11:0] h_active_i, h_fp_i, h_sync_i, h_bp_i;
    logic [11:0] v_active_i, v_fp_i, v_sync_i, v_bp_i;
    logic        hs_pol_i, vs_pol_i;
    logic [2:0]  pattern_i;
    logic [7:0]  solid_r_i, solid_g_i, solid_b_i;
    logic [19:0] ramp_step_i;
    logic        hsync_o, vsync_o, de_o, fv_o;
    logic [7:0]  red_o, green_o, blue_o;
    logic [11:0] x_o, y_o;
    logic        frame_start_o, frame_end_o, line_start_o, cfg_err_o;
    logic [15:0] frame_cnt_o;

    int          n_asserts = 0;
    int          fails = 0;
    int          c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb, c_pat;
    bit          c_hp, c_vp;
    logic [15:0] fc;

    localparam logic [2:0] BAR_TAB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    video_timing_pattern_gen dut (
        .clk_i(clk_i), .resetb_i(resetb_i), .enable_i(enable_i),
        .h_active_i(h_active_i), .h_fp_i(h_fp_i), .h_sync_i(h_sync_i), .h_bp_i(h_bp_i),
        .v_active_i(v_active_i), .v_fp_i(v_fp_i), .v_sync_i(v_sync_i), .v_bp_i(v_bp_i),
        .hs_pol_i(hs_pol_i), .vs_pol_i(vs_pol_i), .pattern_i(pattern_i),
        .solid_r_i(solid_r_i), .solid_g_i(solid_g_i), .solid_b_i(solid_b_i),
        .ramp_step_i(ramp_step_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .fv_o(fv_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .x_o(x_o), .y_o(y_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .line_start_o(line_start_o), .cfg_err_o(cfg_err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit pol, input int pat);
        h_active_i = 12'(ha); h_fp_i = 12'(hf); h_sync_i = 12'(hs); h_bp_i = 12'(hb);
        v_active_i = 12'(va); v_fp_i = 12'(vf); v_sync_i = 12'(vs); v_bp_i = 12'(vb);
        hs_pol_i = pol; vs_pol_i = pol; pattern_i = 3'(pat);
    endtask

    task automatic take_cfg();
        c_ha = int'(h_active_i); c_hf = int'(h_fp_i); c_hs = int'(h_sync_i); c_hb = int'(h_bp_i);
        c_va = int'(v_active_i); c_vf = int'(v_fp_i); c_vs = int'(v_sync_i); c_vb = int'(v_bp_i);
        c_hp = hs_pol_i; c_vp = vs_pol_i; c_pat = int'(pattern_i);
    endtask

    function automatic logic [23:0] model_rgb(input int x, input int y);
        logic [2:0]  c;
        logic [19:0] acc;
        logic [23:0] res;
        int          w, idx;
        bit          mono;
        c = 3'b000; res = 24'h0; mono = 1'b1;
        case (c_pat)
            0: begin res = {solid_r_i, solid_g_i, solid_b_i}; mono = 1'b0; end
            1: c = (x == 0 || x == c_ha - 1 || y == 0 || y == c_va - 1) ? 3'b111 : 3'b000;
            2: begin acc = 20'(x * int'(ramp_step_i)); res = {3{acc[19:12]}}; mono = 1'b0; end
            3: begin
                w = c_ha / 8;
                if (w == 0) c = 3'b111;
                else begin
                    idx = x / w;
                    if (idx > 7) idx = 7;
                    c = BAR_TAB[idx];
                end
            end
            4: c = ((((x >> 5) ^ (y >> 5)) & 1) == 1) ? 3'b111 : 3'b000;
            5: c = ((x >> 5) == (int'(fc) % 128)) ? 3'b111 : 3'b000;
            default: c = 3'b000;
        endcase
        if (mono) res = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
        return res;
    endfunction

    task automatic check_idle(input int k);
        chk("idle_timing", k, 32'({hsync_o, vsync_o, de_o, fv_o}), 32'({!c_hp, !c_vp, 2'b00}));
        chk("idle_pulses", k, 32'({frame_start_o, frame_end_o, line_start_o, cfg_err_o}), 32'(0));
        chk("idle_coord", k, 32'({x_o, y_o}), 32'(0));
        chk("idle_colour", k, 32'({red_o, green_o, blue_o}), 32'(0));
        chk("idle_frame_cnt", k, 32'(frame_cnt_o), 32'(fc));
    endtask

    // n < 0 checks the whole frame; err expects a rejected load at its end.
    task automatic check_frame(input int n, input bit err);
        int ht, vt, total, h, v, lim;
        bit de, fv, hsa, vsa, fs, fe, ls, ce;
        logic [23:0] rgb;
        ht = c_ha + c_hf + c_hs + c_hb;
        vt = c_va + c_vf + c_vs + c_vb;
        total = ht * vt;
        lim = (n < 0) ? total : n;
        for (int k = 0; k < lim; k++) begin
            tick();
            h = k % ht;
            v = k / ht;
            de  = (h < c_ha) && (v < c_va);
            fv  = (v < c_va);
            hsa = (h >= c_ha + c_hf) && (h < c_ha + c_hf + c_hs);
            vsa = (v >= c_va + c_vf) && (v < c_va + c_vf + c_vs);
            fs  = (h == 0) && (v == 0);
            ls  = (h == 0) && (v < c_va);
            fe  = (h == c_ha) && (v == c_va - 1);
            ce  = err && (k == total - 1);
            rgb = de ? model_rgb(h, v) : 24'h0;
            if (fe) fc = fc + 16'd1;
            chk("timing", k, 32'({hsync_o, vsync_o, de_o, fv_o}),
                32'({hsa ? c_hp : !c_hp, vsa ? c_vp : !c_vp, de, fv}));
            chk("pulses", k, 32'({frame_start_o, frame_end_o, line_start_o, cfg_err_o}),
                32'({fs, fe, ls, ce}));
            chk("coord", k, 32'({x_o, y_o}), 32'({12'(de ? h : 0), 12'(de ? v : 0)}));
            chk("colour", k, 32'({red_o, green_o, blue_o}), 32'(rgb));
            chk("frame_cnt", k, 32'(frame_cnt_o), 32'(fc));
        end
    endtask

    initial begin
        resetb_i = 1'b1;
        enable_i = 1'b0;
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 0);
        solid_r_i = 8'h12; solid_g_i = 8'h34; solid_b_i = 8'h56;
        ramp_step_i = 20'h20000;
        c_hp = 1'b0; c_vp = 1'b0; fc = 16'd0;
        #2 resetb_i = 1'b0;
        #1 check_idle(-1);
        tick(); tick();
        resetb_i = 1'b1;
        tick(); tick();
        check_idle(-2);

        // Small timing, positive syncs, started by the enable rise.
        enable_i = 1'b1;
        tick();
        take_cfg();
        check_idle(-3);
        set_cfg(40, 1, 1, 1, 33, 1, 1, 1, 1'b1, 5);
        check_frame(-1, 1'b0);
        take_cfg();
        set_cfg(40, 1, 1, 1, 33, 1, 1, 1, 1'b1, 4);
        check_frame(-1, 1'b0);
        take_cfg();
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 2);
        check_frame(-1, 1'b0);
        take_cfg();
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1);
        check_frame(-1, 1'b0);
        take_cfg();
        set_cfg(19, 2, 2, 2, 4, 1, 1, 1, 1'b1, 3);
        check_frame(-1, 1'b0);
        take_cfg();

        // Zero sync width must be rejected at the frame end.
        set_cfg(8, 2, 0, 2, 4, 1, 1, 1, 1'b1, 0);
        check_frame(-1, 1'b1);
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 0);
        check_frame(-1, 1'b0);
        take_cfg();

        // Abort at v_cnt=2 by dropping enable.
        check_frame(31, 1'b0);
        enable_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check_idle(1000 + i);
        end

        // Re-enable with negative syncs and a new solid colour.
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 0);
        solid_r_i = 8'hA5; solid_g_i = 8'h0F; solid_b_i = 8'hC3;
        enable_i = 1'b1;
        tick();
        take_cfg();
        check_idle(-4);
        check_frame(-1, 1'b0);

        // Asynchronous reset mid-line, checked between clock edges.
        check_frame(5, 1'b0);
        resetb_i = 1'b0;
        #2;
        c_hp = 1'b0; c_vp = 1'b0; fc = 16'd0;
        check_idle(-5);
        resetb_i = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, fails);
        $finish;
    end

endmodule
